// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: pacer FSM states and the frame length in 16x ticks,
// common to the transmitter and its upstream FIFO.
package rs232_pkg;

  localparam int unsigned RS232_FRAME_TICKS = 160;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } rs232_tx_state_e;

endpackage

// File: rtl/rs232_tx_fifo_if.sv
// Host/transmitter-facing signal bundle for rs232_tx_fifo.
// RS232_TX_FIFO_OVF_EN adds OvfClr/Overflow.
interface rs232_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]      WrData;
  logic            WrEn;
  logic            Full;
  logic            Empty;
  logic [ADDR_W:0] Count;
  logic            Send;
  logic [7:0]      DataIn;
`ifdef RS232_TX_FIFO_OVF_EN
  logic            OvfClr;
  logic            Overflow;

  modport master (output WrData, WrEn, OvfClr,
                  input  Full, Empty, Count, Send, DataIn, Overflow);
  modport slave  (input  WrData, WrEn, OvfClr,
                  output Full, Empty, Count, Send, DataIn, Overflow);
`else
  modport master (output WrData, WrEn,
                  input  Full, Empty, Count, Send, DataIn);
  modport slave  (input  WrData, WrEn,
                  output Full, Empty, Count, Send, DataIn);
`endif
endinterface

// File: rtl/rs232_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module rs232_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO plus frame pacer feeding the RS232 transmitter one byte per FRAME_TICKS.
// Optional overflow flag via RS232_TX_FIFO_OVF_EN.
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FRAME_TICKS = RS232_FRAME_TICKS
) (
  input  logic            Clock16x,
  input  logic            Reset,
  rs232_tx_fifo_if.slave  bus
);

  localparam int unsigned     TICK_W    = $clog2(FRAME_TICKS);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(FRAME_TICKS - 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_rd_data;

  rs232_tx_state_e   r_state;
  rs232_tx_state_e   w_state_nxt;
  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_nxt;
  logic              w_send_nxt;
  logic              r_send;
  logic [7:0]        r_data_in;

  // Full is the registered value, so a write alongside a pop from full is dropped.
  assign w_push = bus.WrEn & ~r_full;

  rs232_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (Clock16x),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.WrData),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge Clock16x) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge Clock16x) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // WAIT leaves on the last tick so one frame is 1 IDLE + 1 PULSE + FRAME_TICKS-2 WAIT.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!r_empty) w_state_nxt = ST_PULSE;
      ST_PULSE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (r_tick == TICK_ONE) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    w_send_nxt = 1'b0;
    w_tick_nxt = r_tick;
    unique case (r_state)
      ST_IDLE:  w_pop = ~r_empty;
      ST_PULSE: begin
        w_send_nxt = 1'b1;
        w_tick_nxt = TICK_LOAD;
      end
      ST_WAIT:  w_tick_nxt = r_tick - TICK_ONE;
      default:  w_tick_nxt = '0;
    endcase
  end

  always_ff @(posedge Clock16x) begin
    if (Reset) begin
      r_send    <= 1'b0;
      r_data_in <= '0;
      r_tick    <= '0;
    end else begin
      r_send <= w_send_nxt;
      r_tick <= w_tick_nxt;
      if (w_pop) r_data_in <= w_rd_data;
    end
  end

`ifdef RS232_TX_FIFO_OVF_EN
  logic r_overflow;

  always_ff @(posedge Clock16x) begin
    if (Reset)                    r_overflow <= 1'b0;
    else if (bus.WrEn && r_full)  r_overflow <= 1'b1;
    else if (bus.OvfClr)          r_overflow <= 1'b0;
  end

  assign bus.Overflow = r_overflow;
`endif

  assign bus.Full   = r_full;
  assign bus.Empty  = r_empty;
  assign bus.Count  = r_count;
  assign bus.Send   = r_send;
  assign bus.DataIn = r_data_in;

endmodule
